multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Next-generation MIPS control unit for the multicycle datapath. It replaces the single-cycle opcode decoder with a Moore FSM that sequences fetch, decode, execute, memory and writeback over several cycles.
- Adds parametrised opcode and ALUOp widths, a memory-ready wait handshake, an illegal-opcode trap and an instruction-retired pulse.
- Sits between the instruction register (opcode field) and the multicycle datapath muxes and write enables.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 2, width of ALUOp to the ALU decoder.
- MEM_WAIT_EN, 1. When 1, memory states wait for MemReady. When 0, MemReady is ignored and treated as 1.
- OP_LW, 6'b100011; OP_SW, 6'b101011; OP_RTYPE, 6'b000000; OP_BEQ, 6'b000100; OP_ADDI, 6'b001000; OP_J, 6'b000010. Each is OPCODE_W wide.

Ports:
- CLK  in  1  rising-edge clock.
- RST  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  IR[31:26], sampled in DECODE.
- MemReady  in  1  unified memory has completed the current access.
- IorD, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA, RegWrite, MtoRFSel, RFDSel  out  1 each  datapath controls.
- PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 SignImm, 11 SignImm<<2.
- ALUOp  out  ALUOP_W  00 add, 01 sub, 10 funct-decoded.
- Illegal  out  1  trap flag.
- InstrDone  out  1  one-cycle pulse on instruction retirement.
- State  out  4  current state encoding, for debug.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEXEC=9, ADDIWB=10, JUMP=11, TRAP=12. Codes 13–15 go to FETCH on the next edge.
- Reset: RST low forces State=FETCH immediately.
  - While RST is low, every write enable is forced to 0: PCWrite, IRWrite, MemWrite, RegWrite, Branch.
  - Illegal=0 and InstrDone=0 while RST is low.
  - Mux selects and ALUOp may take their FETCH values.
  - The first fetch begins on the first rising edge after RST goes high.
- Outputs are Moore-decoded from State. The only exception is the memory-state write enables, which are additionally ANDed with MemReady. Any signal not listed for a state is 0.
- FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IRWrite=PCWrite=MemReady.
  - Stay in FETCH while MemReady=0; go to DECODE when MemReady=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - LW or SW → MEMADR.
  - RTYPE → EXECUTE.
  - BEQ → BRANCH.
  - ADDI → ADDIEXEC.
  - J → JUMP.
  - Any other value → TRAP.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Go to MEMREAD if opcode is LW, else MEMWRITE.
- MEMREAD: IorD=1. Wait for MemReady, then go to MEMWB.
- MEMWB: RFDSel=0, MtoRFSel=1, RegWrite=1, InstrDone=1 → FETCH.
- MEMWRITE: IorD=1, MemWrite=MemReady. Wait for MemReady; on MemReady=1 assert InstrDone and go to FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → ALUWB.
- ALUWB: RFDSel=1, MtoRFSel=0, RegWrite=1, InstrDone=1 → FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1, InstrDone=1 → FETCH.
- ADDIEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → ADDIWB.
- ADDIWB: RFDSel=0, MtoRFSel=0, RegWrite=1, InstrDone=1 → FETCH.
- JUMP: PCSrc=10, PCWrite=1, InstrDone=1 → FETCH.
- TRAP: Illegal=1, all write enables 0. TRAP is sticky; only reset exits it.
- Latency with MemReady held at 1:
  - LW 5 cycles.
  - SW, RTYPE and ADDI 4 cycles each.
  - BEQ and J 3 cycles each.
  - Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Opcode is evaluated only in DECODE and MEMADR. Changes in other states are ignored.
- If RST asserts mid-instruction, the state aborts to FETCH asynchronously and no partial write-enable pulse is emitted after the reset edge.
- Outputs carry no X: don't-care fields drive 0.

Test Plan:
- Reset with RST=0 for 3 cycles during MEMWRITE with MemReady=1 → State=0 at once, MemWrite=0. After release, the first edge leaves FETCH with IRWrite=PCWrite=1.
- MemReady=1, opcode=100011 → states 0,1,2,3,4. RegWrite=1 and MtoRFSel=1 only in state 4; InstrDone pulses once, in cycle 5.
- opcode=101011 with MemReady low for 2 cycles in MEMWRITE → State 0,1,2,5,5,5,0. MemWrite=1 only in the third cycle spent in state 5.
- Back-to-back opcode=000000 then 000100 → states 0,1,6,7,0,1,8,0. In state 8: ALUOp=01, PCSrc=01, Branch=1.
- opcode=000010 → states 0,1,11,0 with PCSrc=10 and PCWrite=1 in state 11. opcode=001000 → states 0,1,9,10, with RFDSel=0 in state 10.
- opcode=111111 → State=12 and Illegal=1 held for 20 cycles with all write enables 0. Pulsing RST low returns to State=0 with Illegal=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback.
// Latency: LW 5, SW/RTYPE/ADDI 4, BEQ/J 3 cycles; Moore outputs valid in-cycle.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold while MemReady is low.
module multicycle_control_unit #(
  parameter int OPCODE_W    = 6,
  parameter int ALUOP_W     = 2,
  parameter int MEM_WAIT_EN = 1,
  parameter logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011),
  parameter logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011),
  parameter logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000),
  parameter logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100),
  parameter logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000),
  parameter logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                MemReady,
  output logic                IorD,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                PCWrite,
  output logic                Branch,
  output logic                ALUSrcA,
  output logic                RegWrite,
  output logic                MtoRFSel,
  output logic                RFDSel,
  output logic [1:0]          PCSrc,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic                Illegal,
  output logic                InstrDone,
  output logic [3:0]          State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  state_t state_q, state_d;
  logic   mem_rdy;

  // raw Moore decode before reset gating of enables/flags
  logic iord_r, memw_r, irw_r, pcw_r, br_r, srca_r, regw_r, mtorf_r, rfd_r;
  logic ill_r, done_r;
  logic [1:0] pcsrc_r, srcb_r;
  logic [ALUOP_W-1:0] aluop_r;

  // With waiting disabled the memory is treated as always ready
  assign mem_rdy = (MEM_WAIT_EN != 0) ? MemReady : 1'b1;

  // State register; reset aborts straight to FETCH
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // Next-state: opcode consulted only in DECODE and MEMADR
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_rdy) state_d = S_DECODE;
      S_DECODE: begin
        if (opcode == OP_LW || opcode == OP_SW) state_d = S_MEMADR;
        else if (opcode == OP_RTYPE)            state_d = S_EXECUTE;
        else if (opcode == OP_BEQ)              state_d = S_BRANCH;
        else if (opcode == OP_ADDI)             state_d = S_ADDIEXEC;
        else if (opcode == OP_J)                state_d = S_JUMP;
        else                                    state_d = S_TRAP;
      end
      S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_rdy) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_rdy) state_d = S_FETCH;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_ADDIEXEC: state_d = S_ADDIWB;
      S_ADDIWB:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode; memory-state enables also qualified by readiness
  always_comb begin
    iord_r  = 1'b0;
    memw_r  = 1'b0;
    irw_r   = 1'b0;
    pcw_r   = 1'b0;
    br_r    = 1'b0;
    srca_r  = 1'b0;
    regw_r  = 1'b0;
    mtorf_r = 1'b0;
    rfd_r   = 1'b0;
    ill_r   = 1'b0;
    done_r  = 1'b0;
    pcsrc_r = 2'b00;
    srcb_r  = 2'b00;
    aluop_r = '0;
    case (state_q)
      S_FETCH: begin
        srcb_r = 2'b01;
        irw_r  = mem_rdy;
        pcw_r  = mem_rdy;
      end
      S_DECODE:   srcb_r = 2'b11;
      S_MEMADR: begin
        srca_r = 1'b1;
        srcb_r = 2'b10;
      end
      S_MEMREAD:  iord_r = 1'b1;
      S_MEMWB: begin
        mtorf_r = 1'b1;
        regw_r  = 1'b1;
        done_r  = 1'b1;
      end
      S_MEMWRITE: begin
        iord_r = 1'b1;
        memw_r = mem_rdy;
        done_r = mem_rdy;
      end
      S_EXECUTE: begin
        srca_r  = 1'b1;
        aluop_r = ALUOP_W'(2'b10);
      end
      S_ALUWB: begin
        rfd_r  = 1'b1;
        regw_r = 1'b1;
        done_r = 1'b1;
      end
      S_BRANCH: begin
        srca_r  = 1'b1;
        aluop_r = ALUOP_W'(2'b01);
        pcsrc_r = 2'b01;
        br_r    = 1'b1;
        done_r  = 1'b1;
      end
      S_ADDIEXEC: begin
        srca_r = 1'b1;
        srcb_r = 2'b10;
      end
      S_ADDIWB: begin
        regw_r = 1'b1;
        done_r = 1'b1;
      end
      S_JUMP: begin
        pcsrc_r = 2'b10;
        pcw_r   = 1'b1;
        done_r  = 1'b1;
      end
      S_TRAP:     ill_r = 1'b1;
      default: begin
      end
    endcase
  end

  // Enables and flags are suppressed combinationally while reset is held
  always_comb begin
    IorD      = iord_r;
    ALUSrcA   = srca_r;
    MtoRFSel  = mtorf_r;
    RFDSel    = rfd_r;
    PCSrc     = pcsrc_r;
    ALUSrcB   = srcb_r;
    ALUOp     = aluop_r;
    MemWrite  = memw_r & RST;
    IRWrite   = irw_r  & RST;
    PCWrite   = pcw_r  & RST;
    Branch    = br_r   & RST;
    RegWrite  = regw_r & RST;
    Illegal   = ill_r  & RST;
    InstrDone = done_r & RST;
  end

  assign State = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: instruction-path model plus directed traces.
// Latency: checks every cycle at the falling clock edge.
// Backpressure: MemReady patterns are driven per cycle from bit vectors.
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       MemReady = 1'b1;
  logic       IorD, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA, RegWrite, MtoRFSel, RFDSel;
  logic [1:0] PCSrc, ALUSrcB, ALUOp;
  logic       Illegal, InstrDone;
  logic [3:0] State;

  multicycle_control_unit dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .MemReady(MemReady),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .Branch(Branch), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .MtoRFSel(MtoRFSel),
    .RFDSel(RFDSel), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .Illegal(Illegal), .InstrDone(InstrDone), .State(State)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Instruction-level model: the state path each opcode takes after DECODE
  int m_state = 0;
  int m_path[$];

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_state = 0;
      m_path.delete();
    end else if (m_state == 12) begin
    end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !MemReady) begin
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      case (opcode)
        6'b100011: m_path = '{2, 3, 4};
        6'b101011: m_path = '{2, 5};
        6'b000000: m_path = '{6, 7};
        6'b000100: m_path = '{8};
        6'b001000: m_path = '{9, 10};
        6'b000010: m_path = '{11};
        default:   m_path = '{12};
      endcase
      m_state = m_path.pop_front();
    end else if (m_path.size() > 0) begin
      m_state = m_path.pop_front();
    end else begin
      m_state = 0;
    end
  end

  // Control word each state must present, from the state table
  function automatic logic [16:0] exp_outs(int st, logic mr, logic rst);
    logic iord, memw, irw, pcw, br, srca, regw, mtorf, rfd, ill, done;
    logic [1:0] pcsrc, srcb, aluop;
    iord = 0; memw = 0; irw = 0; pcw = 0; br = 0; srca = 0; regw = 0;
    mtorf = 0; rfd = 0; ill = 0; done = 0; pcsrc = 0; srcb = 0; aluop = 0;
    case (st)
      0:  begin srcb = 2'b01; irw = mr; pcw = mr; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  iord = 1;
      4:  begin mtorf = 1; regw = 1; done = 1; end
      5:  begin iord = 1; memw = mr; done = mr; end
      6:  begin srca = 1; aluop = 2'b10; end
      7:  begin rfd = 1; regw = 1; done = 1; end
      8:  begin srca = 1; aluop = 2'b01; pcsrc = 2'b01; br = 1; done = 1; end
      9:  begin srca = 1; srcb = 2'b10; end
      10: begin regw = 1; done = 1; end
      11: begin pcsrc = 2'b10; pcw = 1; done = 1; end
      12: ill = 1;
      default: begin end
    endcase
    if (!rst) begin
      memw = 0; irw = 0; pcw = 0; regw = 0; br = 0; ill = 0; done = 0;
    end
    return {iord, memw, irw, pcw, br, srca, regw, mtorf, rfd, pcsrc, srcb, aluop, ill, done};
  endfunction

  // Per-cycle traces and captures used by the directed checks
  logic [63:0] st_sh;
  logic [31:0] irw_sh, regw_sh, mtorf_sh, done_sh, memw_sh, br_sh;
  logic [3:0]  cap8;
  logic [2:0]  cap10, cap11;
  int cnt12, cnt_ill, cnt_we12;

  task automatic clear_traces();
    st_sh = '1;
    irw_sh = 0; regw_sh = 0; mtorf_sh = 0; done_sh = 0; memw_sh = 0; br_sh = 0;
    cap8 = 4'b0000; cap10 = 3'b111; cap11 = 3'b000;
    cnt12 = 0; cnt_ill = 0; cnt_we12 = 0;
  endtask

  // Compare DUT against the model every cycle, mid-period
  always @(negedge CLK) begin
    logic [16:0] act, exp;
    exp = exp_outs(m_state, MemReady, RST);
    act = {IorD, MemWrite, IRWrite, PCWrite, Branch, ALUSrcA, RegWrite, MtoRFSel,
           RFDSel, PCSrc, ALUSrcB, ALUOp, Illegal, InstrDone};
    n_checks++;
    if (State !== m_state[3:0] || act !== exp) begin
      n_fail++;
      $display("FAIL cycle_model t=%0t state actual=%0d required=%0d outs actual=%h required=%h",
               $time, State, m_state, act, exp);
    end
    st_sh    = {st_sh[59:0], State};
    irw_sh   = {irw_sh[30:0], IRWrite};
    regw_sh  = {regw_sh[30:0], RegWrite};
    mtorf_sh = {mtorf_sh[30:0], MtoRFSel};
    done_sh  = {done_sh[30:0], InstrDone};
    memw_sh  = {memw_sh[30:0], MemWrite};
    br_sh    = {br_sh[30:0], Branch};
    if (State == 4'd8)  cap8  = {ALUOp, PCSrc};
    if (State == 4'd10) cap10 = {RFDSel, RegWrite, MtoRFSel};
    if (State == 4'd11) cap11 = {PCSrc, PCWrite};
    if (State == 4'd12) begin
      cnt12++;
      if (MemWrite | IRWrite | PCWrite | RegWrite | Branch) cnt_we12++;
    end
    if (Illegal) cnt_ill++;
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Run n cycles; opcode switches from op1 to op2 at cycle index sw; pat MSB = first cycle
  task automatic run(logic [5:0] op1, logic [5:0] op2, int sw, int n, logic [31:0] pat);
    clear_traces();
    for (int i = 0; i < n; i++) begin
      opcode   = (i >= sw) ? op2 : op1;
      MemReady = pat[n-1-i];
      tick();
    end
  endtask

  initial begin
    clear_traces();
    #1 RST = 1'b0;
    tick();
    tick();
    chk("reset_state", 64'(State), 64'd0);
    chk("reset_enables", 64'({IRWrite, PCWrite, MemWrite, RegWrite, Branch, Illegal, InstrDone}), 64'd0);
    RST = 1'b1;

    // LW, no waits
    run(6'b100011, 6'b100011, 99, 5, 32'b11111);
    chk("lw_states", st_sh, 64'hFFFF_FFFF_FFF0_1234);
    chk("lw_first_fetch_irw", 64'(irw_sh[4:0]), 64'b10000);
    chk("lw_regwrite", 64'(regw_sh[4:0]), 64'b00001);
    chk("lw_mtorf", 64'(mtorf_sh[4:0]), 64'b00001);
    chk("lw_done", 64'(done_sh[4:0]), 64'b00001);

    // SW with two wait cycles in MEMWRITE, then FETCH stalled
    run(6'b101011, 6'b101011, 99, 7, 32'b1110010);
    chk("sw_states", st_sh, 64'hFFFF_FFFF_F012_5550);
    chk("sw_memwrite", 64'(memw_sh[6:0]), 64'b0000010);
    chk("sw_done", 64'(done_sh[6:0]), 64'b0000010);
    chk("sw_irwrite", 64'(irw_sh[6:0]), 64'b1000000);

    // LW with one wait cycle in MEMREAD
    run(6'b100011, 6'b100011, 99, 6, 32'b111011);
    chk("lw_wait_states", st_sh, 64'hFFFF_FFFF_FF01_2334);
    chk("lw_wait_done", 64'(done_sh[5:0]), 64'b000001);

    // RTYPE then BEQ; opcode changes during EXECUTE and must be ignored there
    run(6'b000000, 6'b000100, 2, 8, 32'b11111110);
    chk("r_beq_states", st_sh, 64'hFFFF_FFFF_0167_0180);
    chk("r_beq_branch", 64'(br_sh[7:0]), 64'b00000010);
    chk("r_beq_done", 64'(done_sh[7:0]), 64'b00010010);
    chk("r_beq_regwrite", 64'(regw_sh[7:0]), 64'b00010000);
    chk("beq_aluop_pcsrc", 64'(cap8), 64'b0101);

    // J
    run(6'b000010, 6'b000010, 99, 4, 32'b1110);
    chk("j_states", st_sh, 64'hFFFF_FFFF_FFFF_01B0);
    chk("j_pcsrc_pcwrite", 64'(cap11), 64'b101);

    // ADDI
    run(6'b001000, 6'b001000, 99, 5, 32'b11110);
    chk("addi_states", st_sh, 64'hFFFF_FFFF_FFF0_19A0);
    chk("addiwb_rfd_regw_mtorf", 64'(cap10), 64'b010);

    // Reset asserted while in MEMWRITE with MemReady high
    run(6'b101011, 6'b101011, 99, 3, 32'b111);
    chk("memwrite_before_reset", 64'({State, MemWrite}), 64'({4'd5, 1'b1}));
    #1 RST = 1'b0;
    #1 chk("async_reset_abort", 64'({State, MemWrite}), 64'd0);
    tick();
    tick();
    tick();
    RST = 1'b1;
    @(negedge CLK);
    #1 chk("post_reset_fetch_we", 64'({IRWrite, PCWrite}), 64'b11);
    tick();
    chk("post_reset_decode", 64'(State), 64'd1);
    opcode = 6'b000010;
    tick();
    tick();

    // Illegal opcode traps and stays there
    run(6'b111111, 6'b111111, 99, 22, 32'h3FFFFF);
    chk("trap_cycles", 64'(cnt12), 64'd20);
    chk("trap_illegal_cycles", 64'(cnt_ill), 64'd20);
    chk("trap_write_enables", 64'(cnt_we12), 64'd0);
    run(6'b100011, 6'b000000, 1, 3, 32'b010);
    chk("trap_sticky", 64'(State), 64'd12);
    RST = 1'b0;
    #1 chk("trap_reset_exit", 64'({State, Illegal}), 64'd0);
    tick();
    RST = 1'b1;
    MemReady = 1'b0;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
